// File: rtl/hue_stage2.sv
// Final hue stage: scale the Q8.8 quotient by 60, add the sector offset, wrap to 0..359, flag the match window.
// Latency: 3 cycles i_valid -> o_valid, one sample per clock; bubbles pass through unchanged.
// Backpressure: none; the pipeline always advances. Build option HUE_STAGE2_ROUND_EN selects half-up rounding.
module hue_stage2 #(
  parameter int HUE_LO  = 0,
  parameter int HUE_HI  = 20,
  parameter int LATENCY = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_data,
  input  logic [1:0]  i_function,
  input  logic        i_valid,
  output logic [8:0]  o_hue,
  output logic        o_match,
  output logic        o_valid
);

  // The three register stages are hard-wired; any other depth is a build error.
  generate
    if (LATENCY != 3) begin : g_bad_latency
      $error("hue_stage2: LATENCY must be 3");
    end
  endgenerate

  // A window whose low bound exceeds its high bound wraps through 0 degrees.
  localparam bit WIN_WRAPS = (HUE_LO > HUE_HI);

  // 360 degrees and the sector offsets, all in Q.8.
  localparam logic signed [23:0] FULL_TURN = 24'sd92160;
  localparam logic signed [23:0] OFS_G     = 24'sd30720;
  localparam logic signed [23:0] OFS_B     = 24'sd61440;

  // Stage A: quotient * 60, Q15.8. |q| <= 0x8000 keeps the product inside 23 signed bits.
  logic signed [22:0] mul_p;
  logic signed [22:0] a_p;
  logic [1:0]         a_func;
  logic               a_valid;

  assign mul_p = $signed({{7{i_data[15]}}, i_data}) * $signed(23'd60);

  // Stage A registers: product, function code and valid travel together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_p     <= '0;
      a_func  <= '0;
      a_valid <= 1'b0;
    end else begin
      a_p     <= mul_p;
      a_func  <= i_function;
      a_valid <= i_valid;
    end
  end

  // Stage B: add the sector offset; achromatic samples are forced to 0 whatever the quotient.
  logic signed [23:0] b_next;
  logic signed [23:0] b_s;
  logic               b_valid;

  // Select the sector offset from the function code.
  always_comb begin
    b_next = '0;
    case (a_func)
      2'b00:   b_next = {a_p[22], a_p};
      2'b01:   b_next = {a_p[22], a_p} + OFS_G;
      2'b10:   b_next = {a_p[22], a_p} + OFS_B;
      default: b_next = '0;
    endcase
  end

  // Stage B registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      b_s     <= '0;
      b_valid <= 1'b0;
    end else begin
      b_s     <= b_next;
      b_valid <= a_valid;
    end
  end

  // Stage C: lift negatives by one turn, extract the integer degrees, fold 360+ back by one turn.
  // Out-of-range quotients are wrapped exactly once and otherwise left alone.
  logic signed [23:0] s_wrap;
  logic signed [23:0] s_rnd;
  logic [8:0]         h_raw;
  logic [8:0]         h;
  int                 h_int;
  logic               win_hit;
  logic               unused_bits;

  // Wrap, optional rounding, degree extraction and window test.
  always_comb begin
    s_wrap = b_s;
    if (b_s[23]) begin
      s_wrap = b_s + FULL_TURN;
    end
`ifdef HUE_STAGE2_ROUND_EN
    s_rnd = s_wrap + 24'sd128;
`else
    s_rnd = s_wrap;
`endif
    h_raw = s_rnd[16:8];
    h     = h_raw;
    if (h_raw >= 9'd360) begin
      h = h_raw - 9'd360;
    end
    h_int = int'(h);
    if (WIN_WRAPS) begin
      win_hit = (h_int >= HUE_LO) || (h_int <= HUE_HI);
    end else begin
      win_hit = (h_int >= HUE_LO) && (h_int <= HUE_HI);
    end
  end

  // Fraction and high bits of s only matter through the wrap decision and rounding carry.
  assign unused_bits = ^{s_rnd[23:17], s_rnd[7:0], s_wrap[23:17]};

  // Output registers, gated by valid so a bubble never shows stale hue or match.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hue   <= '0;
      o_match <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= b_valid;
      o_hue   <= b_valid ? h : 9'd0;
      o_match <= b_valid & win_hit;
    end
  end

endmodule

// File: tb/tb_hue_stage2.sv
// Directed bench for hue_stage2: two instances share stimulus, one with window 0..20, one wrapped 340..20.
// Every cycle the outputs are compared against the hand-computed entry of the sample issued 3 cycles earlier.
// Reset at start and mid-stream are exercised; expected values honour HUE_STAGE2_ROUND_EN.
module tb_hue_stage2;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [1:0]  func;
  logic        valid;

  logic [8:0]  hue_a, hue_b;
  logic        match_a, match_b;
  logic        valid_a, valid_b;

  int checks   = 0;
  int failures = 0;

  // Expected-output delay line, index 3 is what the outputs should show now.
  logic        q_v [1:3];
  logic [8:0]  q_h [1:3];
  logic        q_ma[1:3];
  logic        q_mb[1:3];
  string       q_t [1:3];

`ifdef HUE_STAGE2_ROUND_EN
  localparam logic [8:0] H_FFFF = 9'd0;
  localparam logic       MA_FFFF = 1'b1;
  localparam logic [8:0] H_0055 = 9'd20;
  localparam logic [8:0] H_FFA6 = 9'd339;
`else
  localparam logic [8:0] H_FFFF = 9'd359;
  localparam logic       MA_FFFF = 1'b0;
  localparam logic [8:0] H_0055 = 9'd19;
  localparam logic [8:0] H_FFA6 = 9'd338;
`endif

  hue_stage2 #(.HUE_LO(0), .HUE_HI(20), .LATENCY(3)) u_a (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_function(func), .i_valid(valid),
    .o_hue(hue_a), .o_match(match_a), .o_valid(valid_a)
  );

  hue_stage2 #(.HUE_LO(340), .HUE_HI(20), .LATENCY(3)) u_b (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_function(func), .i_valid(valid),
    .o_hue(hue_b), .o_match(match_b), .o_valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 1; i <= 3; i++) begin
      q_v[i] = 1'b0; q_h[i] = '0; q_ma[i] = 1'b0; q_mb[i] = 1'b0; q_t[i] = "bubble";
    end
  endtask

  task automatic check_outputs();
    if (q_v[3]) begin
      check({q_t[3], ".valid_a"}, int'(valid_a), 1);
      check({q_t[3], ".valid_b"}, int'(valid_b), 1);
      check({q_t[3], ".hue_a"},   int'(hue_a),   int'(q_h[3]));
      check({q_t[3], ".hue_b"},   int'(hue_b),   int'(q_h[3]));
      check({q_t[3], ".match_a"}, int'(match_a), int'(q_ma[3]));
      check({q_t[3], ".match_b"}, int'(match_b), int'(q_mb[3]));
    end else begin
      check({q_t[3], ".valid_a"}, int'(valid_a), 0);
      check({q_t[3], ".valid_b"}, int'(valid_b), 0);
      check({q_t[3], ".hue_a"},   int'(hue_a),   0);
      check({q_t[3], ".match_a"}, int'(match_a), 0);
      check({q_t[3], ".match_b"}, int'(match_b), 0);
    end
  endtask

  // Drive one input cycle (at a negedge), advance one clock, then check the outputs.
  task automatic step(input logic [15:0] d, input logic [1:0] f, input logic v,
                      input logic [8:0] h, input logic ma, input logic mb, input string tag);
    data  = d;
    func  = f;
    valid = v;
    @(negedge clk);
    for (int i = 3; i >= 2; i--) begin
      q_v[i] = q_v[i-1]; q_h[i] = q_h[i-1]; q_ma[i] = q_ma[i-1]; q_mb[i] = q_mb[i-1]; q_t[i] = q_t[i-1];
    end
    q_v[1]  = v;
    q_h[1]  = h;
    q_ma[1] = ma;
    q_mb[1] = mb;
    q_t[1]  = v ? tag : "bubble";
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(16'h0000, 2'b00, 1'b0, 9'd0, 1'b0, 1'b0, "idle");
    end
  endtask

  initial begin
    rst   = 1'b1;
    data  = '0;
    func  = '0;
    valid = 1'b0;
    clear_model();
    #2;
    q_t[3] = "reset";
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: nothing valid, outputs held at zero.
    idle(10);

    // Sector offsets, back to back.
    step(16'h0080, 2'b00, 1'b1, 9'd30,  1'b0, 1'b0, "r_30");
    step(16'h0000, 2'b01, 1'b1, 9'd120, 1'b0, 1'b0, "g_120");
    step(16'h0100, 2'b10, 1'b1, 9'd300, 1'b0, 1'b0, "b_300");
    step(16'hFF00, 2'b01, 1'b1, 9'd60,  1'b0, 1'b0, "g_60");
    idle(1);

    // Negative wrap and the 359.77 degree rounding boundary.
    step(16'hFF80, 2'b00, 1'b1, 9'd330,  1'b0,    1'b0, "neg_330");
    step(16'hFFFF, 2'b00, 1'b1, H_FFFF,  MA_FFFF, 1'b1, "neg_ffff");
    // Out-of-range quotient lands on exactly 360 and folds to 0.
    step(16'h0200, 2'b10, 1'b1, 9'd0,    1'b1,    1'b1, "over_360");

    // Achromatic: quotient ignored.
    step(16'h00C0, 2'b11, 1'b1, 9'd0, 1'b1, 1'b1, "achro");
    step(16'h7FFF, 2'b11, 1'b1, 9'd0, 1'b1, 1'b1, "achro_junk");
    idle(2);

    // Window edges, plain and wrapped.
    step(16'hFFD6, 2'b00, 1'b1, 9'd350, 1'b0, 1'b1, "win_350");
    step(16'hFF56, 2'b00, 1'b1, 9'd320, 1'b0, 1'b0, "win_320");
    step(16'h0080, 2'b00, 1'b1, 9'd30,  1'b0, 1'b0, "win_30");
    step(16'h0055, 2'b00, 1'b1, H_0055, 1'b1, 1'b1, "win_0055");
    step(16'h0056, 2'b00, 1'b1, 9'd20,  1'b1, 1'b1, "win_20");
    step(16'h005A, 2'b00, 1'b1, 9'd21,  1'b0, 1'b0, "win_21");
    step(16'hFFAB, 2'b00, 1'b1, 9'd340, 1'b0, 1'b1, "win_340");
    step(16'hFFA6, 2'b00, 1'b1, H_FFA6, 1'b0, 1'b0, "win_339m");
    idle(3);

    // Reset mid-stream: three samples in flight, reset the cycle after the third.
    step(16'h0080, 2'b00, 1'b1, 9'd30,  1'b0, 1'b0, "flush_1");
    step(16'h0000, 2'b01, 1'b1, 9'd120, 1'b0, 1'b0, "flush_2");
    step(16'h0100, 2'b10, 1'b1, 9'd300, 1'b0, 1'b0, "flush_3");
    data  = '0;
    func  = '0;
    valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    q_t[3] = "async_rst";
    check_outputs();
    step(16'h0000, 2'b00, 1'b0, 9'd0, 1'b0, 1'b0, "rst_hold");
    rst = 1'b0;
    idle(5);
    step(16'hFF80, 2'b00, 1'b1, 9'd330, 1'b0, 1'b0, "post_rst");
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
